tile_pwr_seq: RTL and testbench



---
 rtl/tile_pwr_seq_pkg.sv | 27 ++
 rtl/tile_pwr_seq.sv | 165 ++++++++++++++++
 tb/tb_tile_pwr_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_pwr_seq_pkg.sv
// Shared types for the per-tile power sequencer.
package tile_pwr_seq_pkg;

    // Sequencer state; the encoding is visible on state_o.
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PRE_RST  = 3'd1,
        ST_RUN      = 3'd2,
        ST_ISOLATE  = 3'd3,
        ST_POST_RST = 3'd4
    } tile_pwr_state_e;

    // Power request payload, kept as a struct so SoC control registers can mux requests later.
    typedef struct packed {
        logic on;
    } tile_pwr_req_t;

    // Largest of three cycle counts; sizes the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/tile_pwr_seq.sv
// Per-tile clock/reset sequencer. Power-on: clock on, reset held, reset released.
// Power-off: isolate NoC, wait for idle (bounded), assert reset, gate clock.
// Valid/ready: a request is taken on a clk_i edge where req_valid_i && req_ready_o;
// ready is high only in OFF and RUN, and the requester holds valid and payload until taken.
module tile_pwr_seq
    import tile_pwr_seq_pkg::*;
#(
    parameter int PreRstCycles  = 4,
    parameter int PostRstCycles = 4,
    parameter int IdleTimeout   = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic       req_on_i,
    output logic       req_ready_o,
    input  logic       tile_idle_i,
    output logic       tile_isolate_o,
    output logic       tile_clk_en_o,
    output logic       tile_rst_no,
    output logic [2:0] state_o,
    output logic       timeout_o,
    output logic       done_o
);

    localparam int CntWidth = $clog2(max3(PreRstCycles, PostRstCycles, IdleTimeout) + 1);

    localparam logic [CntWidth-1:0] PreLoad  = CntWidth'(PreRstCycles - 1);
    localparam logic [CntWidth-1:0] PostLoad = CntWidth'(PostRstCycles - 1);
    localparam logic [CntWidth-1:0] IdleLoad = CntWidth'(IdleTimeout - 1);

    tile_pwr_state_e     state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;
    logic                clk_en_q, clk_en_d;
    logic                rst_n_q, rst_n_d;
    logic                isolate_q, isolate_d;
    logic                req_fire;
    logic                cnt_zero;
    logic [CntWidth-1:0] cnt_dec;

    assign req_ready_o = (state_q == ST_OFF) || (state_q == ST_RUN);
    assign req_fire    = req_valid_i && req_ready_o;
    assign cnt_zero    = (cnt_q == '0);
    // Saturating decrement: never wraps below zero.
    assign cnt_dec     = cnt_zero ? '0 : (cnt_q - CntWidth'(1));

    // Next-state, counter, sticky timeout and done pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (req_fire) begin
                    if (req_on_i) begin
                        state_d = ST_PRE_RST;
                        cnt_d   = PreLoad;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_PRE_RST: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_RUN: begin
                if (req_fire) begin
                    if (req_on_i) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_ISOLATE;
                        cnt_d     = IdleLoad;
                        timeout_d = 1'b0;
                    end
                end
            end
            ST_ISOLATE: begin
                if (tile_idle_i) begin
                    state_d = ST_POST_RST;
                    cnt_d   = PostLoad;
                end else if (cnt_zero) begin
                    state_d   = ST_POST_RST;
                    cnt_d     = PostLoad;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_POST_RST: begin
                if (cnt_zero) begin
                    state_d = ST_OFF;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Output levels decoded from the next state so they can be registered alongside it.
    always_comb begin
        clk_en_d  = 1'b0;
        rst_n_d   = 1'b0;
        isolate_d = 1'b1;
        case (state_d)
            ST_PRE_RST:  clk_en_d = 1'b1;
            ST_RUN: begin
                clk_en_d  = 1'b1;
                rst_n_d   = 1'b1;
                isolate_d = 1'b0;
            end
            ST_ISOLATE: begin
                clk_en_d = 1'b1;
                rst_n_d  = 1'b1;
            end
            ST_POST_RST: clk_en_d = 1'b1;
            default: begin
                clk_en_d  = 1'b0;
                rst_n_d   = 1'b0;
                isolate_d = 1'b1;
            end
        endcase
    end

    // State, counter and glitch-free registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            clk_en_q  <= 1'b0;
            rst_n_q   <= 1'b0;
            isolate_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            clk_en_q  <= clk_en_d;
            rst_n_q   <= rst_n_d;
            isolate_q <= isolate_d;
        end
    end

    assign state_o        = state_q;
    assign timeout_o      = timeout_q;
    assign done_o         = done_q;
    assign tile_clk_en_o  = clk_en_q;
    assign tile_rst_no    = rst_n_q;
    assign tile_isolate_o = isolate_q;

endmodule

// File: tb/tb_tile_pwr_seq.sv
// Directed bench for tile_pwr_seq (PreRstCycles=4, PostRstCycles=4, IdleTimeout=16).
module tb_tile_pwr_seq;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_on;
    logic       req_ready;
    logic       tile_idle;
    logic       tile_isolate;
    logic       tile_clk_en;
    logic       tile_rst_n;
    logic [2:0] state;
    logic       timeout;
    logic       done;

    int checks = 0;
    int errors = 0;

    tile_pwr_seq #(
        .PreRstCycles (4),
        .PostRstCycles(4),
        .IdleTimeout  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_on_i      (req_on),
        .req_ready_o   (req_ready),
        .tile_idle_i   (tile_idle),
        .tile_isolate_o(tile_isolate),
        .tile_clk_en_o (tile_clk_en),
        .tile_rst_no   (tile_rst_n),
        .state_o       (state),
        .timeout_o     (timeout),
        .done_o        (done)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ordering invariants, checked every cycle except edges where rst is applied.
    logic prev_clk_en, prev_rst_n, rst_at_edge;
    always @(negedge clk) begin
        prev_clk_en = tile_clk_en;
        prev_rst_n  = tile_rst_n;
    end
    always @(posedge clk) begin
        rst_at_edge = rst;
        #2;
        if (rst_at_edge === 1'b0 && prev_clk_en !== 1'bx && prev_rst_n !== 1'bx) begin
            checks++;
            if (prev_rst_n === 1'b0 && tile_rst_n === 1'b1 && (prev_clk_en !== 1'b1 || tile_clk_en !== 1'b1)) begin
                errors++;
                $display("FAIL inv_rst_rise_clk_off: clk_en %b->%b rst_n %b->%b", prev_clk_en, tile_clk_en, prev_rst_n, tile_rst_n);
            end
            checks++;
            if (prev_clk_en === 1'b1 && tile_clk_en === 1'b0 && (prev_rst_n !== 1'b0 || tile_rst_n !== 1'b0)) begin
                errors++;
                $display("FAIL inv_clk_fall_rst_off: clk_en %b->%b rst_n %b->%b", prev_clk_en, tile_clk_en, prev_rst_n, tile_rst_n);
            end
        end
    end

    // Driver tasks: all inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic on);
        req_valid = 1'b1;
        req_on    = on;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drive_power_on();
        send_req(1'b1);
        repeat (4) tick();
    endtask

    task automatic drive_power_off();
        tile_idle = 1'b1;
        send_req(1'b0);
        for (int i = 0; i < 40; i++) begin
            if (state === 3'd0) break;
            tick();
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL power_off_bound: state %0d required 0 within 40 cycles", state);
        end
        tile_idle = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
        checks++; if (tile_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b exp 0", tile_clk_en); end
        checks++; if (tile_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rst_n: got %b exp 0", tile_rst_n); end
        checks++; if (tile_isolate !== 1'b1) begin errors++; $display("FAIL reset_isolate: got %b exp 1", tile_isolate); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_power_on();
        logic [2:0] exp_q[$];
        exp_q = {3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
        req_valid = 1'b1;
        req_on    = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL on_ready: got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (tile_clk_en !== 1'b1) begin errors++; $display("FAIL on_clk_en_rise: got %b exp 1", tile_clk_en); end
        // Cycles 0..3 after the handshake: reset still held; cycle 4: released.
        for (int i = 0; i < 6; i++) begin
            logic [2:0] exp_state;
            exp_state = exp_q.pop_front();
            checks++;
            if (state !== exp_state) begin errors++; $display("FAIL on_state[%0d]: got %0d exp %0d", i, state, exp_state); end
            checks++;
            if (tile_rst_n !== (i >= 4)) begin errors++; $display("FAIL on_rst_n[%0d]: got %b exp %b", i, tile_rst_n, (i >= 4)); end
            checks++;
            if (tile_isolate !== (i < 4)) begin errors++; $display("FAIL on_isolate[%0d]: got %b exp %b", i, tile_isolate, (i < 4)); end
            checks++;
            if (done !== (i == 4)) begin errors++; $display("FAIL on_done[%0d]: got %b exp %b", i, done, (i == 4)); end
            tick();
        end
    endtask

    task automatic test_power_off_idle();
        tile_idle = 1'b0;
        send_req(1'b0);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL off_isolate_state: got %0d exp 3", state); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL off_timeout_clear: got %b exp 0", timeout); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (state !== 3'd3 || tile_isolate !== 1'b1 || tile_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL off_wait[%0d]: state %0d iso %b rst_n %b exp 3 1 1", i, state, tile_isolate, tile_rst_n);
            end
        end
        tile_idle = 1'b1;
        tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL off_post_state: got %0d exp 4", state); end
        checks++; if (tile_rst_n !== 1'b0) begin errors++; $display("FAIL off_rst_n_fall: got %b exp 0", tile_rst_n); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tile_clk_en !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL off_hold[%0d]: clk_en %b done %b exp 1 0", i, tile_clk_en, done);
            end
        end
        tick();
        checks++; if (tile_clk_en !== 1'b0) begin errors++; $display("FAIL off_clk_en_fall: got %b exp 0", tile_clk_en); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL off_done: got %b exp 1", done); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL off_final_state: got %0d exp 0", state); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL off_timeout: got %b exp 0", timeout); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL off_done_once: got %b exp 0", done); end
        tile_idle = 1'b0;
    endtask

    task automatic test_timeout();
        drive_power_on();
        tile_idle = 1'b0;
        send_req(1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (state !== 3'd3 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_wait[%0d]: state %0d timeout %b exp 3 0", i, state, timeout);
            end
        end
        tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL to_post_state: got %0d exp 4", state); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b exp 1", timeout); end
        repeat (4) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL to_final_state: got %0d exp 0", state); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_done: got %b exp 1", done); end
        drive_power_on();
        checks++; if (state !== 3'd2 || timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: state %0d timeout %b exp 2 1", state, timeout); end
        send_req(1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear_on_off: got %b exp 0", timeout); end
        tile_idle = 1'b1;
        repeat (5) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL to_second_off: got %0d exp 0", state); end
        tile_idle = 1'b0;
    endtask

    task automatic test_back_to_back();
        tile_idle = 1'b1;
        send_req(1'b1);
        req_valid = 1'b1;
        req_on    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready !== 1'b0 || state !== 3'd1) begin
                errors++;
                $display("FAIL b2b_backpressure[%0d]: ready %b state %0d exp 0 1", i, req_ready, state);
            end
            tick();
        end
        checks++; if (req_ready !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL b2b_run_ready: ready %b state %0d exp 1 2", req_ready, state); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_on_done: got %b exp 1", done); end
        tick();
        req_valid = 1'b0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL b2b_accept: got %0d exp 3", state); end
        tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL b2b_post: got %0d exp 4", state); end
        repeat (4) tick();
        checks++; if (state !== 3'd0 || done !== 1'b1) begin errors++; $display("FAIL b2b_off: state %0d done %b exp 0 1", state, done); end
        tile_idle = 1'b0;
    endtask

    task automatic test_rst_mid();
        send_req(1'b1);
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL rst_pre_setup: got %0d exp 1", state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state !== 3'd0 || tile_clk_en !== 1'b0 || tile_rst_n !== 1'b0 || tile_isolate !== 1'b1 || timeout !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_pre: state %0d clk_en %b rst_n %b iso %b to %b rdy %b exp 0 0 0 1 0 1",
                     state, tile_clk_en, tile_rst_n, tile_isolate, timeout, req_ready);
        end
        drive_power_on();
        tile_idle = 1'b0;
        send_req(1'b0);
        repeat (3) tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL rst_iso_setup: got %0d exp 3", state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state !== 3'd0 || tile_clk_en !== 1'b0 || tile_rst_n !== 1'b0 || tile_isolate !== 1'b1 || timeout !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_iso: state %0d clk_en %b rst_n %b iso %b to %b rdy %b exp 0 0 0 1 0 1",
                     state, tile_clk_en, tile_rst_n, tile_isolate, timeout, req_ready);
        end
    endtask

    task automatic test_redundant();
        drive_power_on();
        send_req(1'b1);
        checks++;
        if (done !== 1'b1 || state !== 3'd2 || tile_clk_en !== 1'b1 || tile_rst_n !== 1'b1 || tile_isolate !== 1'b0) begin
            errors++;
            $display("FAIL red_on: done %b state %0d clk_en %b rst_n %b iso %b exp 1 2 1 1 0",
                     done, state, tile_clk_en, tile_rst_n, tile_isolate);
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL red_on_pulse: got %b exp 0", done); end
        drive_power_off();
        tick();
        send_req(1'b0);
        checks++;
        if (done !== 1'b1 || state !== 3'd0 || tile_clk_en !== 1'b0 || tile_rst_n !== 1'b0 || tile_isolate !== 1'b1) begin
            errors++;
            $display("FAIL red_off: done %b state %0d clk_en %b rst_n %b iso %b exp 1 0 0 0 1",
                     done, state, tile_clk_en, tile_rst_n, tile_isolate);
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL red_off_pulse: got %b exp 0", done); end
    endtask

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Test sequence and final report.
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_on    = 1'b0;
        tile_idle = 1'b0;
        #1;
        test_reset();
        test_power_on();
        test_power_off_idle();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        test_redundant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
